// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {ST_BLANK, ST_SHOW} scan_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}; b and d are lower-case.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Per-digit hex-to-segment decode with a force-blank input.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Scans NUM_DIGITS common-anode digits with per-slot blanking, frame-synced shadow
// registers and optional leading-zero suppression.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 400,
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    update,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int IDX_W = (clog2(NUM_DIGITS) < 2) ? 2 : clog2(NUM_DIGITS);
    localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);

    localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_M1 = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]                presc, blank_cnt;
    logic [IDX_W-1:0]                idx;
    scan_state_e                     state;
    logic [NUM_DIGITS-1:0][3:0]      stage_dig, disp_dig;
    logic [NUM_DIGITS-1:0]           stage_dp, disp_dp;
    logic                            pending;
    logic                            tick, wrap;
    logic [NUM_DIGITS-1:0][6:0]      glyph;

    assign tick = (presc == DIV_M1);
    assign wrap = tick && (idx == LAST_IDX);

    // Digit i is a leading zero when it and every digit to its left are zero.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        if (i == 0) begin : g_lsd
            seven_seg_decoder u_dec (
                .nibble (disp_dig[i]),
                .blank  (1'b0),
                .seg    (glyph[i])
            );
        end else begin : g_upper
            seven_seg_decoder u_dec (
                .nibble (disp_dig[i]),
                .blank  (blank_lz && (disp_dig[NUM_DIGITS-1:i] == '0)),
                .seg    (glyph[i])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            blank_cnt  <= '0;
            idx        <= '0;
            state      <= ST_BLANK;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
            stage_dig  <= '0;
            stage_dp   <= '0;
            disp_dig   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 1'b1;
            frame_done <= wrap;

            if (tick) begin
                idx       <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                state     <= ST_BLANK;
                blank_cnt <= '0;
                an        <= '1;
                seg       <= SEG_BLANK;
                dp        <= 1'b1;
            end else if (state == ST_BLANK) begin
                if (blank_cnt == BLANK_M1) begin
                    state <= ST_SHOW;
                    an    <= ~(NUM_DIGITS'(1) << idx);
                    seg   <= glyph[idx];
                    dp    <= ~disp_dp[idx];
                end else begin
                    blank_cnt <= blank_cnt + 1'b1;
                end
            end else begin
                // Keep refreshing so a blank_lz change takes effect within the slot.
                seg <= glyph[idx];
                dp  <= ~disp_dp[idx];
            end

            if (update) begin
                stage_dig <= digits_in;
                stage_dp  <= dp_in;
            end
            if (wrap && update) begin
                disp_dig <= digits_in;
                disp_dp  <= dp_in;
                pending  <= 1'b0;
            end else if (wrap && pending) begin
                disp_dig <= stage_dig;
                disp_dp  <= stage_dp;
                pending  <= 1'b0;
            end else if (update) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: a time-based reference model queues the expected pins per cycle,
// a monitor pops and compares on the falling edge.
module tb_seven_seg_scan_driver;

    localparam int CLK_HZ = 1000;
    localparam int SCAN_HZ = 100;
    localparam int N = 4;
    localparam int BC = 2;
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int FRAME = DIV * N;

    logic           clk = 1'b0;
    logic           reset;
    logic [4*N-1:0] digits_in;
    logic [N-1:0]   dp_in;
    logic           update;
    logic           blank_lz;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           dp;
    logic           frame_done;

    seven_seg_scan_driver #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_DIGITS(N), .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .update(update), .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic         fd;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: cycles since reset, the frame's display data and the staged data.
    int             t;
    logic [4*N-1:0] m_disp, m_stage;
    logic [N-1:0]   m_ddp, m_sdp;
    bit             m_pend;

    task automatic model_edge();
        exp_t e;
        bit   wrap;
        int   pos, ix;
        wrap = 1'b0;
        if (reset) begin
            t = 0; m_disp = '0; m_stage = '0; m_ddp = '0; m_sdp = '0; m_pend = 1'b0;
        end else begin
            wrap = (t % FRAME) == FRAME - 1;
            if (wrap && update) begin
                m_disp = digits_in; m_ddp = dp_in; m_pend = 1'b0;
            end else if (wrap && m_pend) begin
                m_disp = m_stage; m_ddp = m_sdp; m_pend = 1'b0;
            end else if (update) begin
                m_pend = 1'b1;
            end
            if (update) begin m_stage = digits_in; m_sdp = dp_in; end
            t++;
        end
        pos = t % DIV;
        ix  = (t / DIV) % N;
        e.an = '1; e.seg = 7'h7F; e.dp = 1'b1; e.fd = wrap;
        if (pos >= BC) begin
            e.an = ~(N'(1) << ix);
            if (blank_lz && ix > 0 && (m_disp >> (4 * ix)) == 0)
                e.seg = 7'h7F;
            else
                e.seg = GLYPH[m_disp[4*ix +: 4]];
            e.dp = ~m_ddp[ix];
        end
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #2;
        end
    endtask

    task automatic load(input logic [4*N-1:0] d, input logic [N-1:0] p);
        digits_in = d; dp_in = p; update = 1'b1;
        step(1);
        update = 1'b0;
    endtask

    task automatic advance_to(input int phase);
        int guard = 0;
        while ((t % FRAME) != phase && guard < 2 * FRAME) begin
            step(1);
            guard++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if ({an, seg, dp, frame_done} !== e) begin
                miscompares++;
                $display("FAIL pins t=%0d: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                         t, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            vectors++;
            if ($countones(~an) > 1) begin
                miscompares++;
                $display("FAIL anode_onehot t=%0d: got an=%b, want at most one low", t, an);
            end
        end
    end

    initial begin
        logic [4*N-1:0] d;
        int k;
        reset = 1'b1; digits_in = '0; dp_in = '0; update = 1'b0; blank_lz = 1'b0;
        t = 0; m_disp = '0; m_stage = '0; m_ddp = '0; m_sdp = '0; m_pend = 1'b0;
        step(2);
        reset = 1'b0;

        load(16'h1234, 4'b0101);
        step(2 * FRAME);

        blank_lz = 1'b1;
        load(16'h00A5, 4'b1000);
        step(2 * FRAME);
        load(16'h0000, 4'b0000);
        step(2 * FRAME);

        blank_lz = 1'b0;
        advance_to(2 * DIV + 3);
        load(16'hBEEF, 4'b0010);
        step(2 * FRAME);

        advance_to(5);
        load(16'h1111, 4'b0001);
        step(7);
        load(16'h2222, 4'b0100);
        step(2 * FRAME);

        advance_to(FRAME - 1);
        load(16'h3C3C, 4'b1111);
        step(FRAME);

        advance_to(2 * DIV + 5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(FRAME + 5);

        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            k = $urandom_range(0, N);
            for (int j = 0; j < k; j++) d[4*(N-1-j) +: 4] = 4'h0;
            blank_lz = 1'($urandom);
            load(d, N'($urandom));
            step($urandom_range(1, 60));
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                step(1);
                reset = 1'b0;
            end
        end
        step(FRAME);

        @(posedge clk);
        #6;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
